// File: rtl/shift_feeder_pkg.sv
// rtl/shift_feeder_pkg.sv - state encodings and direction constants for shift_feeder
package shift_feeder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/strobe_prescaler.sv
// rtl/strobe_prescaler.sv - free-running 0..period counter; tick on the terminal count
module strobe_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = run && (cnt == period);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_feeder.sv
// rtl/shift_feeder.sv - serialises a parallel word onto din/en/dir of a shift register
// Optional word repeat enabled by SHIFT_FEEDER_REPEAT_EN.
module shift_feeder
    import shift_feeder_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_dir,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DIV_W-1:0]  div,
    output logic              dout,
    output logic              en_out,
    output logic              dir_out,
    output logic              busy,
    output logic              done
`ifdef SHIFT_FEEDER_REPEAT_EN
    ,
    input  logic              repeat_word
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(DATA_W);

    logic [1:0]        state;
    logic [DATA_W-1:0] data_q;
    logic [DIV_W-1:0]  div_q;
    logic              dir_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_q;
    logic              tick;
    logic              run;
    logic              rpt;
    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shifted;

`ifdef SHIFT_FEEDER_REPEAT_EN
    assign rpt = repeat_word;
`else
    assign rpt = 1'b0;
`endif

    assign run     = (state == ST_SHIFT) && (bit_cnt != ALL_BITS);
    assign bit_idx = (dir_q == DIR_RIGHT) ? bit_cnt : LAST_BIT - bit_cnt;
    assign shifted = data_q >> bit_idx;

    strobe_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_SHIFT),
        .run   (run),
        .period(div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            dout    <= 1'b0;
            en_out  <= 1'b0;
            done    <= 1'b0;
        end else begin
            en_out <= 1'b0;
            done   <= last_q;
            last_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        data_q  <= s_data;
                        dir_q   <= s_dir;
                        div_q   <= div;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        en_out <= 1'b1;
                        dout   <= shifted[0];
                        if (bit_cnt == LAST_BIT) begin
                            last_q  <= 1'b1;
                            // a repeated word restarts the bit count without leaving SHIFT
                            bit_cnt <= rpt ? '0 : ALL_BITS;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (last_q && bit_cnt == ALL_BITS) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready = (state == ST_IDLE);
    assign busy    = (state == ST_SHIFT);
    assign dir_out = dir_q;

endmodule

// File: tb/tb_shift_feeder.sv
// tb/tb_shift_feeder.sv - randomized self-checking bench with a schedule-based reference model
module tb_shift_feeder;

    localparam int DATA_W = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_dir = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DIV_W-1:0]  div = '0;
    logic              dout, en_out, dir_out, busy, done;
    logic              repeat_word = 1'b0;

    always #5 clk = ~clk;

    shift_feeder #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_dir  (s_dir),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .div    (div),
        .dout   (dout),
        .en_out (en_out),
        .dir_out(dir_out),
        .busy   (busy),
        .done   (done)
`ifdef SHIFT_FEEDER_REPEAT_EN
        ,
        .repeat_word(repeat_word)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Reference model: each accepted word becomes a schedule of absolute cycle numbers.
    int                cyc = 0;
    bit                exp_en[int];
    bit                exp_bit[int];
    bit                exp_done[int];
    int                busy_lo = 1, busy_hi = 0, ready_at = 0;
    logic              exp_dir = 1'b0;
    logic [DATA_W-1:0] cur_data = '0;
    logic              cur_dir = 1'b0;
    int                cur_p = 1;
    int                cur_last = -1;
    int                acc_cnt = 0;
    int                last_t = 0;
    logic [DATA_W-1:0] q = '0;

    int   log_c[$];
    logic log_b[$];
    int   done_log[$];

    function automatic void schedule(input int base);
        for (int k = 0; k < DATA_W; k++) begin
            int c = base + (k + 1) * cur_p;
            exp_en[c]  = 1'b1;
            exp_bit[c] = cur_dir ? cur_data[k] : cur_data[DATA_W-1-k];
        end
        cur_last = base + DATA_W * cur_p;
        exp_done[cur_last + 1] = 1'b1;
        busy_hi  = cur_last;
        ready_at = cur_last + 2;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_en.delete();
            exp_bit.delete();
            exp_done.delete();
            busy_lo  = 1;
            busy_hi  = 0;
            ready_at = cyc;
            exp_dir  = 1'b0;
            cur_last = -1;
            q        = '0;
        end else begin
            if (en_out) q = dir_out ? {dout, q[DATA_W-1:1]} : {q[DATA_W-2:0], dout};
            if (s_valid && (cyc - 1) >= ready_at) begin
                cur_data = s_data;
                cur_dir  = s_dir;
                cur_p    = int'(div) + 1;
                exp_dir  = s_dir;
                busy_lo  = cyc;
                last_t   = cyc;
                acc_cnt++;
                schedule(cyc);
            end else if (cyc == cur_last && repeat_word) begin
                schedule(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit e;
            e = exp_en.exists(cyc);
            chk("en_out", en_out, e);
            if (e) chk("dout", dout, exp_bit[cyc]);
            chk("done", done, exp_done.exists(cyc));
            chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
            chk("s_ready", s_ready, cyc >= ready_at);
            chk("dir_out", dir_out, exp_dir);
            if (exp_done.exists(cyc)) chk("q_at_done", q, cur_data);
            if (en_out) begin
                log_c.push_back(cyc);
                log_b.push_back(dout);
            end
            if (done) done_log.push_back(cyc);
        end
    end

    task automatic clear_logs();
        log_c.delete();
        log_b.delete();
        done_log.delete();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic dr, input int dv, output int t);
        int n0;
        n0 = acc_cnt;
        s_data  = d;
        s_dir   = dr;
        div     = DIV_W'(dv);
        s_valid = 1'b1;
        for (int i = 0; i < 500 && acc_cnt == n0; i++) begin
            @(posedge clk);
            #1;
        end
        if (acc_cnt == n0) chk("accept_timeout", 0, 1);
        t = last_t;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 500 && cyc < ready_at; i++) begin
            @(posedge clk);
            #1;
        end
        if (cyc < ready_at) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_word(input string tag, input int t, input int p,
                              input logic [DATA_W-1:0] bits, input logic [DATA_W-1:0] qv);
        chk({tag, "_nstrobe"}, log_c.size(), DATA_W);
        for (int i = 0; i < DATA_W && i < log_c.size(); i++) begin
            chk({tag, "_strobe_at"}, log_c[i] - t, (i + 1) * p);
            chk({tag, "_bit"}, log_b[i], bits[DATA_W-1-i]);
        end
        chk({tag, "_ndone"}, done_log.size(), 1);
        if (done_log.size() > 0) chk({tag, "_done_at"}, done_log[0] - t, DATA_W * p + 1);
        chk({tag, "_q"}, q, qv);
    endtask

    initial begin
        int t, t2, n;
        #100000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        int t, t2, n;
        logic [DATA_W-1:0] w;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_s_ready", s_ready, 1);
            chk("rst_en", en_out, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;

        clear_logs();
        send(4'b1011, 1'b0, 0, t);
        s_valid = 1'b0;
        wait_idle();
        check_word("t2", t, 1, 4'b1011, 4'b1011);

        clear_logs();
        send(4'b1011, 1'b1, 2, t);
        s_valid = 1'b0;
        wait_idle();
        check_word("t3", t, 3, 4'b1101, 4'b1011);

        clear_logs();
        send(4'b0101, 1'b0, 1, t);
        s_valid = 1'b0;
        for (int i = 0; i < 100 && log_c.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        pulse_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("t4_nstrobe", log_c.size(), 2);
        chk("t4_ndone", done_log.size(), 0);
        chk("t4_s_ready", s_ready, 1);
        clear_logs();
        send(4'b0110, 1'b0, 0, t);
        s_valid = 1'b0;
        wait_idle();
        check_word("t4b", t, 1, 4'b0110, 4'b0110);

        clear_logs();
        send(4'b1100, 1'b0, 0, t);
        send(4'b0011, 1'b1, 0, t2);
        s_valid = 1'b0;
        wait_idle();
        chk("t5_second_accept", t2 - t, DATA_W + 3);
        chk("t5_q", q, 4'b0011);

`ifdef SHIFT_FEEDER_REPEAT_EN
        clear_logs();
        repeat_word = 1'b1;
        send(4'b0110, 1'b0, 1, t);
        s_valid = 1'b0;
        for (int i = 0; i < 200 && done_log.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        repeat_word = 1'b0;
        wait_idle();
        chk("t6_nstrobe", log_c.size(), 3 * DATA_W);
        for (int i = 0; i < log_c.size(); i++) chk("t6_spacing", log_c[i] - t, 2 * (i + 1));
        chk("t6_ndone", done_log.size(), 3);
        for (int i = 0; i < done_log.size(); i++) chk("t6_done_at", done_log[i] - t, 9 + 8 * i);
`endif

        for (int it = 0; it < 40; it++) begin
            w = DATA_W'($urandom);
            send(w, 1'($urandom), $urandom_range(0, 3), t);
            if ($urandom_range(0, 3) == 0) begin
                s_data = DATA_W'($urandom);
                s_dir  = 1'($urandom);
                div    = DIV_W'($urandom_range(0, 3));
            end else begin
                s_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(1, 10);
                repeat (n) @(posedge clk);
                #1;
                pulse_reset();
            end
            if (!s_valid) begin
                wait_idle();
                n = $urandom_range(0, 3);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
